// File: rtl/mem_writer.sv
`default_nettype none
// ============================================================================
// mem_writer : writes a valid/ready byte stream into consecutive CPU_MEM
//              locations through the macro's active-low csb0/web0 port.
//              Optional macro MEM_WRITER_CHECKSUM_EN enables o_checksum.
// Revision   : 1.0  initial release
// ============================================================================
module mem_writer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_checksum
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   C_MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   C_LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic              w_start_ok;
  logic              w_hs;
  logic [ADDR_W:0]   w_len;

  assign w_start_ok = (r_state == S_IDLE) && i_start;
  assign w_len      = (i_len > C_MAX_LEN) ? C_MAX_LEN : i_len;
  // o_ready depends only on registered state so i_valid never loops back
  assign o_ready    = (r_state == S_ACTIVE) && (r_remaining != '0);
  assign w_hs       = i_valid && o_ready;
  assign o_busy     = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (w_len == '0) ? S_DONE : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_hs && (r_remaining == C_LEN_ONE)) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      csb0        <= 1'b1;
      web0        <= 1'b1;
      addr0       <= '0;
      din0        <= '0;
      o_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      o_done  <= (w_state_nxt == S_DONE);
      csb0    <= ~w_hs;
      web0    <= ~w_hs;
      if (w_start_ok) begin
        r_addr      <= i_base_addr;
        r_remaining <= w_len;
      end else if (w_hs) begin
        r_addr      <= r_addr + C_ADDR_ONE;
        r_remaining <= r_remaining - C_LEN_ONE;
      end
      if (w_hs) begin
        addr0 <= r_addr;
        din0  <= i_data;
      end
    end
  end

`ifdef MEM_WRITER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_hs) begin
      r_checksum <= r_checksum + i_data;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_writer.sv
`default_nettype none
// ============================================================================
// tb_mem_writer : table-driven bench for mem_writer with a behavioural
//                 256x8 memory model on the csb0/web0 port.
// Revision      : 1.0  initial release
// ============================================================================
module tb_mem_writer;

  logic       i_clk = 1'b0;
  logic       i_resetn;
  logic       i_start;
  logic [7:0] i_base_addr;
  logic [8:0] i_len;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       csb0;
  logic       web0;
  logic [7:0] addr0;
  logic [7:0] din0;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_checksum;

  mem_writer #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .csb0        (csb0),
    .web0        (web0),
    .addr0       (addr0),
    .din0        (din0),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_checksum  (o_checksum)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string name;
    int    base;
    int    len;
    int    d0;
    int    step;
    int    vpat;
    int    restart;
    int    exp_done;
    int    exp_writes;
    int    exp_sum;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] mem[256];
  logic [7:0] exp_mem[256];
  logic       mem_clear;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  // Behavioural single-port macro: a strobe presented in a cycle lands at its closing edge
  always @(posedge i_clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (csb0 === 1'b0 && web0 === 1'b0) begin
      mem[addr0] <= din0;
      wr_cnt     <= wr_cnt + 1;
    end
  end

  always @(negedge i_clk) begin
    if (o_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic mem_check(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== exp_mem[i]) bad++;
    end
    chk(nm, bad, 0);
  endtask

  task automatic run_xfer(input vec_t v);
    int   idx, cyc, done_cyc, busy_err, wr0, sum_at_done, ready_at_done, exp_sum;
    logic hs;
    wr0 = wr_cnt; idx = 0; cyc = 1; done_cyc = -1; busy_err = 0;
    sum_at_done = -1; ready_at_done = -1;
    @(negedge i_clk);
    i_start = 1'b1; i_base_addr = 8'(v.base); i_len = 9'(v.len); i_valid = 1'b0;
    @(posedge i_clk); #1;
    while (done_cyc < 0 && cyc < 700) begin
      i_start = (cyc == v.restart);
      if (i_start) begin
        i_base_addr = 8'h00;
        i_len       = 9'd2;
      end
      i_valid = v.vpat[(cyc - 1) % 8];
      i_data  = 8'(v.d0 + v.step * idx);
      @(negedge i_clk);
      if (o_busy !== 1'b1) busy_err++;
      if (o_done === 1'b1) begin
        done_cyc      = cyc;
        sum_at_done   = int'(o_checksum);
        ready_at_done = int'(o_ready);
      end
      hs = i_valid & o_ready;
      @(posedge i_clk); #1;
      if (hs === 1'b1) idx++;
      cyc++;
    end
    i_start = 1'b0; i_valid = 1'b0;
    for (int i = 0; i < v.exp_writes; i++) exp_mem[8'(v.base + i)] = 8'(v.d0 + v.step * i);
`ifdef MEM_WRITER_CHECKSUM_EN
    exp_sum = v.exp_sum;
`else
    exp_sum = 0;
`endif
    @(negedge i_clk);
    chk({v.name, " done_cycle"}, done_cyc, v.exp_done);
    chk({v.name, " write_count"}, wr_cnt - wr0, v.exp_writes);
    chk({v.name, " busy_low_cycles"}, busy_err, 0);
    chk({v.name, " ready_in_done"}, ready_at_done, 0);
    chk({v.name, " busy_after_done"}, o_busy, 1'b0);
    chk({v.name, " checksum"}, sum_at_done, exp_sum);
    mem_check({v.name, " memory"});
  endtask

  initial begin
    int wr0, dn0;
    //           name       base  len  d0    step  vpat  rst done wr   sum
    vecs[0] = '{"b2b",     'h10, 4,   'hA1, 'h11, 'hFF, 0,  6,   4,   'hEA};
    vecs[1] = '{"gap",     'h40, 3,   'h11, 'h11, 'h29, 0,  8,   3,   'h66};
    vecs[2] = '{"gap2",    'hC0, 2,   'hF0, 'h01, 'h11, 0,  7,   2,   'hE1};
    vecs[3] = '{"wrap",    'hFE, 4,   'h01, 'h01, 'hFF, 0,  6,   4,   'h0A};
    vecs[4] = '{"zero",    'h33, 0,   'h77, 'h00, 'hFF, 0,  1,   0,   'h00};
    vecs[5] = '{"single",  'h80, 1,   'h7E, 'h00, 'hFF, 0,  3,   1,   'h7E};
    vecs[6] = '{"restart", 'h50, 8,   'h90, 'h01, 'hFF, 3,  10,  8,   'h9C};
    vecs[7] = '{"full",    'h00, 256, 'h00, 'h01, 'hFF, 0,  258, 256, 'h80};
    vecs[8] = '{"clamp",   'h20, 511, 'h03, 'h02, 'hFF, 0,  258, 256, 'h00};

    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    i_resetn = 1'b1; i_start = 1'b0; i_base_addr = 8'h00; i_len = 9'd0;
    i_data = 8'h00; i_valid = 1'b0; mem_clear = 1'b1;
    #2 i_resetn = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    mem_clear = 1'b0;
    chk("reset o_ready", o_ready, 1'b0);
    chk("reset csb0", csb0, 1'b1);
    chk("reset web0", web0, 1'b1);
    chk("reset addr0", addr0, 8'h00);
    chk("reset din0", din0, 8'h00);
    chk("reset o_busy", o_busy, 1'b0);
    chk("reset o_done", o_done, 1'b0);
    chk("reset o_checksum", o_checksum, 8'h00);
    i_resetn = 1'b1;

    for (int k = 0; k < 9; k++) run_xfer(vecs[k]);

    // Reset while the third byte's strobe is on the bus: only two bytes may land
    wr0 = wr_cnt; dn0 = done_cnt;
    @(negedge i_clk);
    i_start = 1'b1; i_base_addr = 8'h60; i_len = 9'd5;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_valid = 1'b1; i_data = 8'hC0;
    @(posedge i_clk); #1; i_data = 8'hC1;
    @(posedge i_clk); #1; i_data = 8'hC2;
    @(posedge i_clk); #1;
    chk("midreset csb0_before", csb0, 1'b0);
    i_resetn = 1'b0;
    #1;
    chk("midreset csb0_async", csb0, 1'b1);
    chk("midreset web0_async", web0, 1'b1);
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_resetn = 1'b1;
    exp_mem[8'h60] = 8'hC0;
    exp_mem[8'h61] = 8'hC1;
    repeat (2) @(negedge i_clk);
    chk("midreset write_count", wr_cnt - wr0, 2);
    chk("midreset done_pulses", done_cnt - dn0, 0);
    chk("midreset busy", o_busy, 1'b0);
    mem_check("midreset memory");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
